regfile_sb: RTL and testbench

Parametrised integer register file with a per-register pending-write scoreboard for the five-stage RISC-V core. Decode reads N source operands combinationally. It claims a destination register at issue. Writeback retires that claim and writes the data. Each read port reports whether its register still has an outstanding write, so hazard logic can stall without tracking destinations itself. An optional same-cycle write-to-read bypass removes the writeback-to-decode bubble.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_pend_ctr.sv | 56 +++++
 rtl/regfile_sb.sv | 126 ++++++++++++
 tb/tb_regfile_sb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the regfile_sb register file.
//   XLEN_DEF / NREGS_DEF / PEND_W_DEF : default parameter values
//   port_lo()                         : low bit index of a port slice in a flattened bus
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREGS_DEF  = 32;
    localparam int PEND_W_DEF = 2;

    // Port i of a bus of width-w fields occupies bits [i*w +: w].
    function automatic int port_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_pend_ctr.sv
// Saturating pending-write counter for one architectural register.
//   clock, reset_n : clock and asynchronous active-low reset
//   inc            : claim request (refused while full)
//   dec            : writeback retiring one claim (floors at zero)
//   clr            : synchronous clear, wins over inc/dec
//   full           : counter saturated and no same-cycle retire; claim refused
//   nz             : counter non-zero (register has outstanding writes)
//   one            : counter equals one (a lone retire empties it)
module regfile_pend_ctr
    import regfile_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic full,
    output logic nz,
    output logic one
);

    logic [PEND_W-1:0] cnt_r;
    logic [PEND_W-1:0] cnt_s;

    // A retire in the same cycle frees a slot, so a saturated counter still
    // accepts a claim that is paired with a writeback.
    assign full = (&cnt_r) & ~dec;
    assign nz   = |cnt_r;
    assign one  = (cnt_r == PEND_W'(1));

    // Next-count selection: clear, then net claim, then net retire.
    always_comb begin
        cnt_s = cnt_r;
        if (clr) begin
            cnt_s = '0;
        end else if (inc && !dec && !full) begin
            cnt_s = cnt_r + PEND_W'(1);
        end else if (dec && !inc && nz) begin
            cnt_s = cnt_r - PEND_W'(1);
        end else begin
            cnt_s = cnt_r;
        end
    end

    // Counter state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with a per-register pending-write scoreboard.
//   clock, reset_n      : clock and asynchronous active-low reset
//   rd_addr / rd_data   : NREAD combinational read ports (flattened)
//   rd_busy             : per-port outstanding-write flag
//   iss_en / iss_addr   : destination claim at issue; iss_full when refused
//   wr_en/addr/data     : writeback, retires one claim and stores data
//   flush               : clears all pending counters, data untouched
//   wr_err              : sticky flag, writeback to a register with no claim
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    parameter int PEND_W = PEND_W_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  iss_en,
    input  logic [AW-1:0]         iss_addr,
    output logic                  iss_full,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  flush,
    output logic                  wr_err
);

    logic [XLEN-1:0]  mem_r [NREGS];
    logic [NREGS-1:0] pc_nz_s;
    logic [NREGS-1:0] pc_full_s;
    logic [NREGS-1:0] pc_one_s;
    logic             iss_ok_s;
    logic             wb_zero_s;
    logic             wb_clears_s;
    logic             wr_err_r;

    // x0 has no counter: never busy, never full.
    assign pc_nz_s[0]   = 1'b0;
    assign pc_full_s[0] = 1'b0;
    assign pc_one_s[0]  = 1'b0;

    for (genvar r = 1; r < NREGS; r++) begin : g_ctr
        regfile_pend_ctr #(.PEND_W(PEND_W)) u_ctr (
            .clock   (clock),
            .reset_n (reset_n),
            .inc     (iss_en && (iss_addr == AW'(r))),
            .dec     (wr_en && (wr_addr == AW'(r))),
            .clr     (flush),
            .full    (pc_full_s[r]),
            .nz      (pc_nz_s[r]),
            .one     (pc_one_s[r])
        );
    end

    assign iss_full = iss_en && (iss_addr != AW'(0)) && pc_full_s[iss_addr];
    assign iss_ok_s = iss_en && (iss_addr != AW'(0)) && !pc_full_s[iss_addr];

    // A retire with no claim outstanding is an error unless a claim on the same
    // register lands in the same cycle and cancels it.
    assign wb_zero_s = wr_en && (wr_addr != AW'(0)) && !pc_nz_s[wr_addr]
                     && !(iss_ok_s && (iss_addr == wr_addr));

    // A lone retire of the last claim: the bypassed reader sees the register free.
    assign wb_clears_s = wr_en && (wr_addr != AW'(0)) && pc_one_s[wr_addr]
                       && !(iss_en && (iss_addr == wr_addr));

    for (genvar p = 0; p < NREAD; p++) begin : g_rd
        localparam int LO_A = port_lo(p, AW);
        localparam int LO_D = port_lo(p, XLEN);
        logic [AW-1:0]   addr_s;
        logic            hit_s;
        logic [XLEN-1:0] data_s;
        logic            busy_s;

        assign addr_s = rd_addr[LO_A +: AW];
        assign hit_s  = (BYPASS != 0) && wr_en && (wr_addr == addr_s) && (addr_s != AW'(0));

        // Read mux with optional same-cycle writeback forwarding.
        always_comb begin
            data_s = '0;
            busy_s = 1'b0;
            if (addr_s == AW'(0)) begin
                data_s = '0;
                busy_s = 1'b0;
            end else if (hit_s) begin
                data_s = wr_data;
                busy_s = pc_nz_s[addr_s] && !wb_clears_s;
            end else begin
                data_s = mem_r[addr_s];
                busy_s = pc_nz_s[addr_s];
            end
        end

        assign rd_data[LO_D +: XLEN] = data_s;
        assign rd_busy[p]            = busy_s;
    end

    // Register storage; x0 is never written so it stays at its reset value.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en && (wr_addr != AW'(0))) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Sticky writeback-without-claim error flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_err_r <= 1'b0;
        end else if (wb_zero_s) begin
            wr_err_r <= 1'b1;
        end
    end

    assign wr_err = wr_err_r;

endmodule

// File: tb/tb_regfile_sb.sv
module tb_regfile_sb;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int AW     = 5;

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic [AW-1:0]     ra0 = '0, ra1 = '0;
    logic [2*AW-1:0]   rd_addr;
    logic [2*XLEN-1:0] rd_data_b, rd_data_n;
    logic [1:0]        busy_b, busy_n;
    logic              full_b, full_n, err_b, err_n;
    logic              iss_en = 1'b0, wr_en = 1'b0, flush = 1'b0;
    logic [AW-1:0]     iss_addr = '0, wr_addr = '0;
    logic [XLEN-1:0]   wr_data = '0;

    logic [XLEN-1:0] m_mem [NREGS];
    int              m_pc  [NREGS];
    bit              m_err;
    int total = 0, bad = 0;

    assign rd_addr = {ra1, ra0};
    always #5 clock = ~clock;

    regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1), .PEND_W(2)) dut (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .rd_busy(busy_b), .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(full_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .wr_err(err_b));

    regfile_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(0), .PEND_W(2)) dut_nb (
        .clock(clock), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
        .rd_busy(busy_n), .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(full_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .flush(flush), .wr_err(err_n));

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int r = 0; r < NREGS; r++) begin
            m_mem[r] = '0;
            m_pc[r]  = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic bit exp_full();
        return iss_en && iss_addr != 0 && m_pc[iss_addr] == 3 && !(wr_en && wr_addr == iss_addr);
    endfunction

    function automatic bit claim_on(int r);
        return iss_en && r != 0 && int'(iss_addr) == r && !exp_full();
    endfunction

    // Pending count after this edge, flush not considered.
    function automatic int next_pc(int r);
        bit i = claim_on(r);
        bit d = wr_en && r != 0 && int'(wr_addr) == r;
        if (i && d) return m_pc[r];
        if (i) return m_pc[r] + 1;
        if (d) return (m_pc[r] == 0) ? 0 : m_pc[r] - 1;
        return m_pc[r];
    endfunction

    function automatic logic [XLEN-1:0] exp_data(int a, bit byp);
        if (a == 0) return '0;
        if (byp && wr_en && int'(wr_addr) == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic bit exp_busy(int a, bit byp);
        if (a == 0) return 1'b0;
        if (byp && wr_en && int'(wr_addr) == a && next_pc(a) == 0) return 1'b0;
        return m_pc[a] != 0;
    endfunction

    task automatic model_edge();
        int nxt [NREGS];
        for (int r = 0; r < NREGS; r++) nxt[r] = flush ? 0 : next_pc(r);
        if (wr_en && wr_addr != 0 && m_pc[wr_addr] == 0 && !claim_on(int'(wr_addr))) m_err = 1'b1;
        if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
        for (int r = 0; r < NREGS; r++) m_pc[r] = nxt[r];
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #2;
    endtask

    task automatic idle();
        iss_en = 1'b0; wr_en = 1'b0; flush = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (rd_data_b !== '0) begin bad++; $display("FAIL reset_data got=%h exp=0", rd_data_b); end
        total++; if (busy_b !== 2'b00 || busy_n !== 2'b00) begin bad++; $display("FAIL reset_busy got=%b/%b exp=00", busy_b, busy_n); end
        total++; if (full_b !== 1'b0 || err_b !== 1'b0) begin bad++; $display("FAIL reset_flags got full=%b err=%b exp=0", full_b, err_b); end
        #10 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        ra0 = 5'd5; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
        tick();
        idle();
        #1;
        total++; if (rd_data_n[31:0] !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_reset_x5 got=%h exp=deadbeef", rd_data_n[31:0]); end
        total++; if (err_b !== 1'b1) begin bad++; $display("FAIL pre_reset_err got=%b exp=1", err_b); end
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (rd_data_b[31:0] !== 32'h0 || rd_data_n[31:0] !== 32'h0) begin bad++; $display("FAIL midreset_x5 got=%h/%h exp=0", rd_data_b[31:0], rd_data_n[31:0]); end
        total++; if (busy_b !== 2'b00 || err_b !== 1'b0 || err_n !== 1'b0) begin bad++; $display("FAIL midreset_flags got busy=%b err=%b exp=0", busy_b, err_b); end
        #3 reset_n = 1'b1;
        tick();
    endtask

    task automatic test_x0_err();
        ra0 = 5'd0; ra1 = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        tick();
        idle(); iss_en = 1'b1; iss_addr = 5'd0;
        #2;
        total++; if (rd_data_b[31:0] !== 32'h0 || full_b !== 1'b0) begin bad++; $display("FAIL x0_write got=%h full=%b exp=0", rd_data_b[31:0], full_b); end
        tick();
        idle();
        #2;
        total++; if (busy_b[0] !== 1'b0 || err_b !== 1'b0) begin bad++; $display("FAIL x0_issue got busy=%b err=%b exp=0", busy_b[0], err_b); end
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h0000_4444;
        tick();
        idle();
        #2;
        total++; if (err_b !== 1'b1 || err_n !== 1'b1) begin bad++; $display("FAIL wr_err_set got=%b/%b exp=1", err_b, err_n); end
        total++; if (rd_data_n[63:32] !== 32'h4444) begin bad++; $display("FAIL x4_written got=%h exp=4444", rd_data_n[63:32]); end
        tick(); tick();
        total++; if (err_b !== 1'b1) begin bad++; $display("FAIL wr_err_sticky got=%b exp=1", err_b); end
    endtask

    task automatic test_bypass();
        ra0 = 5'd7; ra1 = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1234;
        #2;
        total++; if (rd_data_b[31:0] !== 32'h1234) begin bad++; $display("FAIL bypass_same got=%h exp=1234", rd_data_b[31:0]); end
        total++; if (rd_data_n[31:0] !== exp_data(7, 1'b0) || rd_data_n[31:0] === 32'h1234) begin bad++; $display("FAIL nobypass_old got=%h exp=%h", rd_data_n[31:0], exp_data(7, 1'b0)); end
        tick();
        idle();
        #2;
        total++; if (rd_data_n[63:32] !== 32'h1234) begin bad++; $display("FAIL nobypass_next got=%h exp=1234", rd_data_n[63:32]); end
    endtask

    task automatic test_scoreboard();
        ra0 = 5'd3; ra1 = 5'd3;
        iss_en = 1'b1; iss_addr = 5'd3;
        tick(); tick();
        idle(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        tick();
        idle();
        #2;
        total++; if (busy_b !== 2'b11 || busy_n !== 2'b11) begin bad++; $display("FAIL sb_one_left got=%b/%b exp=11", busy_b, busy_n); end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h34;
        #2;
        total++; if (busy_b !== 2'b00 || busy_n !== 2'b11) begin bad++; $display("FAIL sb_last_wb got=%b/%b exp=00/11", busy_b, busy_n); end
        tick();
        idle();
        #2;
        total++; if (busy_b !== 2'b00 || busy_n !== 2'b00) begin bad++; $display("FAIL sb_cleared got=%b/%b exp=00", busy_b, busy_n); end
    endtask

    task automatic test_saturation();
        ra0 = 5'd9;
        iss_en = 1'b1; iss_addr = 5'd9;
        for (int k = 0; k < 3; k++) tick();
        #2;
        total++; if (full_b !== 1'b1 || full_n !== 1'b1) begin bad++; $display("FAIL sat_fourth got=%b/%b exp=1", full_b, full_n); end
        tick();
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        #2;
        total++; if (full_b !== 1'b0) begin bad++; $display("FAIL sat_iss_wb got=%b exp=0", full_b); end
        tick();
        wr_en = 1'b0;
        #2;
        total++; if (full_b !== 1'b1 || m_pc[9] != 3) begin bad++; $display("FAIL sat_still3 got=%b exp=1", full_b); end
        idle(); wr_en = 1'b1; wr_addr = 5'd9;
        tick(); tick();
        #2;
        total++; if (busy_n[0] !== 1'b1) begin bad++; $display("FAIL sat_drain2 got=%b exp=1", busy_n[0]); end
        tick();
        idle();
        #2;
        total++; if (busy_n[0] !== 1'b0 || err_b !== m_err) begin bad++; $display("FAIL sat_drained got=%b err=%b exp=0/%b", busy_n[0], err_b, m_err); end
    endtask

    task automatic test_flush();
        ra0 = 5'd2; ra1 = 5'd6;
        iss_en = 1'b1; iss_addr = 5'd2;
        tick(); tick();
        iss_addr = 5'd6;
        tick();
        idle();
        #2;
        total++; if (busy_b !== 2'b11) begin bad++; $display("FAIL flush_pre got=%b exp=11", busy_b); end
        flush = 1'b1; wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'hAA;
        tick();
        idle();
        #2;
        total++; if (busy_b !== 2'b00 || busy_n !== 2'b00) begin bad++; $display("FAIL flush_busy got=%b/%b exp=00", busy_b, busy_n); end
        total++; if (rd_data_n[31:0] !== 32'hAA) begin bad++; $display("FAIL flush_data got=%h exp=aa", rd_data_n[31:0]); end
    endtask

    task automatic test_random();
        logic [XLEN-1:0] got_d;
        bit              got_b;
        int              a;
        for (int n = 0; n < 400; n++) begin
            ra0      = 5'($urandom_range(0, 7));
            ra1      = 5'($urandom_range(0, 7));
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = 5'($urandom_range(0, 7));
            wr_en    = 1'($urandom_range(0, 2) == 0);
            wr_addr  = 5'($urandom_range(0, 7));
            wr_data  = $urandom;
            flush    = 1'($urandom_range(0, 24) == 0);
            if (iss_en && wr_en && iss_addr == wr_addr && m_pc[wr_addr] == 0) iss_en = 1'b0;
            #2;
            for (int byp = 0; byp < 2; byp++) begin
                for (int p = 0; p < 2; p++) begin
                    a     = (p == 0) ? int'(ra0) : int'(ra1);
                    got_d = (byp == 1) ? rd_data_b[p*XLEN +: XLEN] : rd_data_n[p*XLEN +: XLEN];
                    got_b = (byp == 1) ? busy_b[p] : busy_n[p];
                    total++;
                    if (got_d !== exp_data(a, 1'(byp))) begin
                        bad++; $display("FAIL rand_data n=%0d byp=%0d port=%0d got=%h exp=%h", n, byp, p, got_d, exp_data(a, 1'(byp)));
                    end
                    total++;
                    if (got_b !== exp_busy(a, 1'(byp))) begin
                        bad++; $display("FAIL rand_busy n=%0d byp=%0d port=%0d got=%b exp=%b", n, byp, p, got_b, exp_busy(a, 1'(byp)));
                    end
                end
            end
            total++;
            if (full_b !== exp_full() || full_n !== exp_full()) begin
                bad++; $display("FAIL rand_full n=%0d got=%b/%b exp=%b", n, full_b, full_n, exp_full());
            end
            total++;
            if (err_b !== m_err || err_n !== m_err) begin
                bad++; $display("FAIL rand_err n=%0d got=%b/%b exp=%b", n, err_b, err_n, m_err);
            end
            tick();
        end
        idle();
    endtask

    initial begin
        #1;
        test_reset();
        test_reset_mid();
        test_x0_err();
        test_bypass();
        test_scoreboard();
        test_saturation();
        test_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
